wb_delay_fwd: RTL and testbench

Parametrised writeback delay pipeline for the core's register-file write path. Carries each writeback request (enable, address, value) through DELAY registered stages with all fields aligned. It drives the register-file write port from the last stage. It also provides combinational forwarding lookups over every in-flight write so decode-stage read ports can bypass values not yet committed. Supports stall and tracks a pending-write count.

---
 rtl/wb_delay_fwd.sv | 114 +++++++++++
 tb/tb_wb_delay_fwd.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_delay_fwd.sv
// Writeback delay pipeline: carries register-file writes through DELAY aligned stages.
// It also forwards in-flight values to the decode read ports.
module wb_delay_fwd #(
    parameter int DELAY  = 2,
    parameter int N_RD   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_reg_wr_en,
    input  logic [ADDR_W-1:0]            i_reg_wr_addr,
    input  logic [DATA_W-1:0]            i_reg_wr_val,
    input  logic                         i_stall,
    input  logic [N_RD*ADDR_W-1:0]       i_rd_addr,
    output logic [N_RD-1:0]              o_fwd_hit,
    output logic [N_RD*DATA_W-1:0]       o_fwd_val,
    output logic                         o_reg_wr_en,
    output logic [ADDR_W-1:0]            o_ff_addr,
    output logic [DATA_W-1:0]            o_ff_val,
    output logic [$clog2(DELAY+1)-1:0]   o_pending
);

    localparam int CNT_W = $clog2(DELAY+1);

    logic [DELAY-1:0]             v_q,    v_d;
    logic [DELAY-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DELAY-1:0][DATA_W-1:0] val_q,  val_d;
    logic [CNT_W-1:0]             pending_q, pending_d;
    logic                         req_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [DELAY-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < DELAY; k++) begin
            cnt = cnt + CNT_W'(vec[k]);
        end
        return cnt;
    endfunction

    // Writes to x0 are architecturally discarded, so they never occupy a valid slot.
    assign req_s = i_reg_wr_en & (i_reg_wr_addr != {ADDR_W{1'b0}});

    // Next-state: shift one stage per unstalled cycle, otherwise hold everything.
    always_comb begin
        v_d    = v_q;
        addr_d = addr_q;
        val_d  = val_q;
        if (!i_stall) begin
            v_d[0]    = req_s;
            addr_d[0] = i_reg_wr_addr;
            val_d[0]  = i_reg_wr_val;
            for (int k = 1; k < DELAY; k++) begin
                v_d[k]    = v_q[k-1];
                addr_d[k] = addr_q[k-1];
                val_d[k]  = val_q[k-1];
            end
        end else begin
            v_d    = v_q;
            addr_d = addr_q;
            val_d  = val_q;
        end
        pending_d = popcount(v_d);
    end

    // Stage and pending-count registers; reset beats stall and incoming requests.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q       <= '0;
            addr_q    <= '0;
            val_q     <= '0;
            pending_q <= '0;
        end else begin
            v_q       <= v_d;
            addr_q    <= addr_d;
            val_q     <= val_d;
            pending_q <= pending_d;
        end
    end

    // Commit is gated by stall so a held oldest entry is written exactly once.
    assign o_reg_wr_en = v_q[DELAY-1] & ~i_stall;
    assign o_ff_addr   = addr_q[DELAY-1];
    assign o_ff_val    = val_q[DELAY-1];
    assign o_pending   = pending_q;

    for (genvar p = 0; p < N_RD; p++) begin : g_port
        logic [ADDR_W-1:0] rd_addr_s;
        logic              match_s;
        logic              hit_s;
        logic [DATA_W-1:0] val_s;

        assign rd_addr_s = i_rd_addr[p*ADDR_W +: ADDR_W];

        // Scan oldest to youngest so later (younger) matches overwrite older ones.
        always_comb begin
            hit_s   = 1'b0;
            val_s   = {DATA_W{1'b0}};
            match_s = 1'b0;
            for (int k = DELAY - 1; k >= 0; k--) begin
                match_s = v_q[k] & (addr_q[k] == rd_addr_s) & (rd_addr_s != {ADDR_W{1'b0}});
                hit_s   = match_s ? 1'b1     : hit_s;
                val_s   = match_s ? val_q[k] : val_s;
            end
            match_s = req_s & (i_reg_wr_addr == rd_addr_s) & (rd_addr_s != {ADDR_W{1'b0}});
            hit_s   = match_s ? 1'b1         : hit_s;
            val_s   = match_s ? i_reg_wr_val : val_s;
        end

        assign o_fwd_hit[p]                = hit_s;
        assign o_fwd_val[p*DATA_W +: DATA_W] = val_s;
    end

endmodule

// File: tb/tb_wb_delay_fwd.sv
// Directed self-checking bench for wb_delay_fwd with DELAY=2, N_RD=2.
module tb_wb_delay_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_val;
    logic        stall;
    logic [9:0]  rd_addr;
    logic [1:0]  fwd_hit;
    logic [63:0] fwd_val;
    logic        reg_wr_en;
    logic [4:0]  ff_addr;
    logic [31:0] ff_val;
    logic [1:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    wb_delay_fwd #(.DELAY(2), .N_RD(2), .DATA_W(32), .ADDR_W(5)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_reg_wr_en   (wr_en),
        .i_reg_wr_addr (wr_addr),
        .i_reg_wr_val  (wr_val),
        .i_stall       (stall),
        .i_rd_addr     (rd_addr),
        .o_fwd_hit     (fwd_hit),
        .o_fwd_val     (fwd_val),
        .o_reg_wr_en   (reg_wr_en),
        .o_ff_addr     (ff_addr),
        .o_ff_val      (ff_val),
        .o_pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_val = 32'd0;
        stall = 1'b0; rd_addr = {5'd5, 5'd5};
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_wr_en",   64'(reg_wr_en), 64'd0);
        check("rst_pending", 64'(pending),   64'd0);
        check("rst_hit",     64'(fwd_hit),   64'd0);
        check("rst_ff_addr", 64'(ff_addr),   64'd0);
        check("rst_ff_val",  64'(ff_val),    64'd0);

        // Basic latency: request at edge N commits between N+1 and N+2.
        wr_en = 1'b1; wr_addr = 5'd5; wr_val = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        settle();
        check("lat_e1_wr_en",   64'(reg_wr_en),   64'd0);
        check("lat_e1_pending", 64'(pending),     64'd1);
        check("lat_e1_hit0",    64'(fwd_hit[0]),  64'd1);
        check("lat_e1_val0",    64'(fwd_val[31:0]), 64'hDEADBEEF);
        tick();
        check("lat_e2_wr_en",   64'(reg_wr_en), 64'd1);
        check("lat_e2_addr",    64'(ff_addr),   64'd5);
        check("lat_e2_val",     64'(ff_val),    64'hDEADBEEF);
        tick();
        check("lat_e3_wr_en",   64'(reg_wr_en), 64'd0);
        check("lat_e3_pending", 64'(pending),   64'd0);

        // x0 drop
        wr_en = 1'b1; wr_addr = 5'd0; wr_val = 32'h1234; rd_addr = {5'd0, 5'd0};
        settle();
        check("x0_hit_in", 64'(fwd_hit), 64'd0);
        tick();
        wr_en = 1'b0;
        settle();
        check("x0_pending", 64'(pending),   64'd0);
        check("x0_hit_s0",  64'(fwd_hit),   64'd0);
        tick();
        check("x0_wr_en_a", 64'(reg_wr_en), 64'd0);
        tick();
        check("x0_wr_en_b", 64'(reg_wr_en), 64'd0);

        // Forward priority: youngest of two same-address writes wins
        wr_en = 1'b1; wr_addr = 5'd7; wr_val = 32'd1;
        tick();
        wr_val = 32'd2;
        tick();
        wr_en = 1'b0; rd_addr = {5'd0, 5'd7};
        settle();
        check("pri_hit",      64'(fwd_hit[0]),    64'd1);
        check("pri_val",      64'(fwd_val[31:0]), 64'd2);
        check("pri_pending",  64'(pending),       64'd2);
        check("pri_c1_en",    64'(reg_wr_en),     64'd1);
        check("pri_c1_val",   64'(ff_val),        64'd1);
        tick();
        check("pri_c2_en",    64'(reg_wr_en),     64'd1);
        check("pri_c2_val",   64'(ff_val),        64'd2);
        check("pri_s1_val",   64'(fwd_val[31:0]), 64'd2);
        tick();
        check("pri_done_en",  64'(reg_wr_en),     64'd0);

        // Input bypass on port 1, miss on port 0
        wr_en = 1'b1; wr_addr = 5'd3; wr_val = 32'hAA; rd_addr = {5'd3, 5'd4};
        settle();
        check("byp_hit1", 64'(fwd_hit[1]),     64'd1);
        check("byp_val1", 64'(fwd_val[63:32]), 64'hAA);
        check("byp_hit0", 64'(fwd_hit[0]),     64'd0);
        check("byp_val0", 64'(fwd_val[31:0]),  64'd0);
        wr_en = 1'b0;
        settle();

        // Stall for 3 cycles; a held upstream request must not be captured
        wr_en = 1'b1; wr_addr = 5'd9; wr_val = 32'h99; rd_addr = {5'd12, 5'd9};
        tick();
        stall = 1'b1; wr_addr = 5'd12; wr_val = 32'h55;
        settle();
        check("stl_hold_hit_in",  64'(fwd_hit[1]),     64'd1);
        check("stl_hold_val_in",  64'(fwd_val[63:32]), 64'h55);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_wr_en",   64'(reg_wr_en),     64'd0);
            check("stl_pending", 64'(pending),       64'd1);
            check("stl_hit9",    64'(fwd_val[31:0]), 64'h99);
        end
        stall = 1'b0; wr_en = 1'b0;
        settle();
        check("stl_rel_wr_en", 64'(reg_wr_en), 64'd0);
        tick();
        check("stl_commit_en",   64'(reg_wr_en), 64'd1);
        check("stl_commit_addr", 64'(ff_addr),   64'd9);
        check("stl_commit_val",  64'(ff_val),    64'h99);
        // Stall while the oldest stage is valid gates the commit
        stall = 1'b1;
        settle();
        check("stl_gate_en", 64'(reg_wr_en), 64'd0);
        tick();
        check("stl_gate_pending", 64'(pending), 64'd1);
        stall = 1'b0;
        settle();
        check("stl_gate_rel_en", 64'(reg_wr_en), 64'd1);
        tick();
        check("stl_once_en",      64'(reg_wr_en), 64'd0);
        check("stl_once_pending", 64'(pending),   64'd0);

        // Reset mid-flight discards both in-flight writes
        wr_en = 1'b1; wr_addr = 5'd4; wr_val = 32'h44;
        tick();
        wr_addr = 5'd6; wr_val = 32'h66;
        tick();
        wr_en = 1'b0; rd_addr = {5'd6, 5'd4};
        settle();
        check("rmf_pending", 64'(pending), 64'd2);
        stall = 1'b1; rst = 1'b1;
        settle();
        check("rmf_stall_en", 64'(reg_wr_en), 64'd0);
        tick();
        rst = 1'b0; stall = 1'b0;
        settle();
        check("rmf_pending0", 64'(pending),   64'd0);
        check("rmf_wr_en",    64'(reg_wr_en), 64'd0);
        check("rmf_hit",      64'(fwd_hit),   64'd0);
        tick();
        check("rmf_wr_en_b",  64'(reg_wr_en), 64'd0);
        tick();
        check("rmf_wr_en_c",  64'(reg_wr_en), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
